// File: rtl/reg_pipe_elastic_if.sv
// rtl/reg_pipe_elastic_if.sv - enq/deq handshake bundle for reg_pipe_elastic (COUNT present with REG_PIPE_COUNT_EN)
interface reg_pipe_elastic_if #(
    parameter int width = 1
`ifdef REG_PIPE_COUNT_EN
    ,
    parameter int cwidth = 2
`endif
);
    logic [width-1:0]  D_IN;
    logic              ENQ;
    logic              RDY_ENQ;
    logic [width-1:0]  Q_OUT;
    logic              VALID_OUT;
    logic              DEQ;
`ifdef REG_PIPE_COUNT_EN
    logic [cwidth-1:0] COUNT;
`endif

    // Producer/consumer side
    modport master (
        output D_IN,
        output ENQ,
        output DEQ,
        input  RDY_ENQ,
        input  Q_OUT,
        input  VALID_OUT
`ifdef REG_PIPE_COUNT_EN
        ,
        input  COUNT
`endif
    );

    // Pipeline side
    modport slave (
        input  D_IN,
        input  ENQ,
        input  DEQ,
        output RDY_ENQ,
        output Q_OUT,
        output VALID_OUT
`ifdef REG_PIPE_COUNT_EN
        ,
        output COUNT
`endif
    );
endinterface

// File: rtl/reg_pipe_elastic.sv
// rtl/reg_pipe_elastic.sv - elastic bubble-collapsing register pipeline; REG_PIPE_COUNT_EN adds COUNT, BSV_NO_ASSERT silences protocol warnings
module reg_pipe_elastic #(
    parameter int               width  = 1,
    parameter int               depth  = 2,
    parameter logic [width-1:0] init   = '0,
    parameter int               cwidth = 2
) (
    input  logic              CLK,
    input  logic              RST,
    reg_pipe_elastic_if.slave pipe
);

    // The occupancy count must be able to represent a completely full pipe.
    if ((2 ** cwidth) <= depth) begin : g_cwidth_check
        $error("reg_pipe_elastic: cwidth too small for depth");
    end

    // Data stages carry a power-on value only; reset never touches them.
    logic [depth-1:0][width-1:0] data_q = {depth{init}};

    logic [depth-1:0] valid_q;
    logic [depth-1:0] valid_d;
    logic [depth-1:0] adv;
    logic [depth-1:0] load;
    logic             rdy;
    logic             enq_fire;

    // Advance chain: the output stage drains on DEQ, every other stage moves
    // when the stage ahead is empty or is itself moving this cycle.
    always_comb begin
        adv            = '0;
        adv[depth-1]   = valid_q[depth-1] & pipe.DEQ;
        for (int i = depth - 2; i >= 0; i--) begin
            adv[i] = valid_q[i] & (~valid_q[i+1] | adv[i+1]);
        end
    end

    // Stage 0 can take an item when empty or when its occupant moves on.
    assign rdy      = ~RST & (~valid_q[0] | adv[0]);
    assign enq_fire = pipe.ENQ & rdy;

    // Next valid bits and per-stage load strobes.
    always_comb begin
        valid_d = valid_q;
        load    = '0;
        if (enq_fire) begin
            valid_d[0] = 1'b1;
            load[0]    = 1'b1;
        end else if (adv[0]) begin
            valid_d[0] = 1'b0;
        end
        for (int i = 1; i < depth; i++) begin
            if (adv[i-1]) begin
                valid_d[i] = 1'b1;
                load[i]    = 1'b1;
            end else if (adv[i]) begin
                valid_d[i] = 1'b0;
            end
        end
    end

    // Valid bits are the only reset state; reset drops everything in flight.
    always_ff @(posedge CLK) begin
        if (RST) begin
            valid_q <= '0;
        end else begin
            valid_q <= valid_d;
        end
    end

    // Data stages load only when written; they hold through reset.
    always_ff @(posedge CLK) begin
        if (!RST) begin
            if (load[0]) begin
                data_q[0] <= pipe.D_IN;
            end
            for (int i = 1; i < depth; i++) begin
                if (load[i]) begin
                    data_q[i] <= data_q[i-1];
                end
            end
        end
    end

    assign pipe.RDY_ENQ   = rdy;
    assign pipe.Q_OUT     = data_q[depth-1];
    assign pipe.VALID_OUT = valid_q[depth-1];

`ifdef REG_PIPE_COUNT_EN
    logic [cwidth-1:0] count_q;
    logic [cwidth-1:0] count_d;

    // Occupancy moves by one on a lone enqueue or a lone dequeue.
    always_comb begin
        count_d = count_q;
        if (enq_fire && !adv[depth-1]) begin
            count_d = count_q + 1'b1;
        end else if (!enq_fire && adv[depth-1]) begin
            count_d = count_q - 1'b1;
        end
    end

    // Occupancy register, cleared together with the valid bits.
    always_ff @(posedge CLK) begin
        if (RST) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign pipe.COUNT = count_q;
`endif

`ifndef BSV_NO_ASSERT
`ifndef SYNTHESIS
    // Report handshake misuse; the offending request is simply ignored.
    always_ff @(posedge CLK) begin
        if (!RST && pipe.ENQ && !rdy) begin
            $warning("reg_pipe_elastic: ENQ while not ready ignored");
        end
        if (!RST && pipe.DEQ && !valid_q[depth-1]) begin
            $warning("reg_pipe_elastic: DEQ while empty ignored");
        end
    end
`endif
`endif

endmodule

// File: tb/tb_reg_pipe_elastic.sv
// tb/tb_reg_pipe_elastic.sv - self-checking bench for reg_pipe_elastic (depth 3 and depth 1 instances)
module tb_reg_pipe_elastic;
    localparam int DA = 3;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    reg_pipe_elastic_if #(.width(8)
`ifdef REG_PIPE_COUNT_EN
        , .cwidth(2)
`endif
    ) a_if ();

    reg_pipe_elastic_if #(.width(1)
`ifdef REG_PIPE_COUNT_EN
        , .cwidth(2)
`endif
    ) b_if ();

    reg_pipe_elastic #(.width(8), .depth(DA), .init(8'hA5), .cwidth(2)) u_a (
        .CLK  (clk),
        .RST  (rst),
        .pipe (a_if)
    );

    reg_pipe_elastic #(.width(1), .depth(1), .init(1'b0), .cwidth(2)) u_b (
        .CLK  (clk),
        .RST  (rst),
        .pipe (b_if)
    );

    int checks = 0;
    int errors = 0;

    // Reference: ordered list of items, each with a stage position.
    int m_data[$];
    int m_pos[$];

    function automatic int imin(input int x, input int y);
        return (x < y) ? x : y;
    endfunction

    function automatic bit m_head_leaves();
        return (m_pos.size() > 0) && (m_pos[0] == DA - 1) && (a_if.DEQ === 1'b1);
    endfunction

    // Stage 0 is free after every item has moved as far as it may.
    function automatic bit m_rdy();
        int prev;
        int s;
        if (rst) return 1'b0;
        s    = m_head_leaves() ? 1 : 0;
        prev = DA;
        for (int k = s; k < m_pos.size(); k++) prev = imin(m_pos[k] + 1, prev - 1);
        return prev > 0;
    endfunction

    function automatic bit m_valid();
        return (m_pos.size() > 0) && (m_pos[0] == DA - 1);
    endfunction

    task automatic model_step();
        bit r;
        int prev;
        r = m_rdy();
        if (rst) begin
            m_data.delete();
            m_pos.delete();
        end else begin
            if (m_head_leaves()) begin
                void'(m_data.pop_front());
                void'(m_pos.pop_front());
            end
            prev = DA;
            for (int k = 0; k < m_pos.size(); k++) begin
                m_pos[k] = imin(m_pos[k] + 1, prev - 1);
                prev     = m_pos[k];
            end
            if (a_if.ENQ && r) begin
                m_data.push_back(int'(a_if.D_IN));
                m_pos.push_back(0);
            end
        end
    endtask

    task automatic tick();
        model_step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        a_if.ENQ = 1'b1; a_if.DEQ = 1'b1; a_if.D_IN = 8'h77;
        b_if.ENQ = 1'b0; b_if.DEQ = 1'b0; b_if.D_IN = 1'b0;
        #1;
        checks++; if (a_if.Q_OUT !== 8'hA5) begin errors++; $display("FAIL poweron_q got %h exp a5", a_if.Q_OUT); end
        for (int c = 0; c < 2; c++) begin
            checks++; if (a_if.RDY_ENQ !== 1'b0) begin errors++; $display("FAIL reset_rdy cyc %0d got %b exp 0", c, a_if.RDY_ENQ); end
            tick();
        end
        rst = 1'b0; a_if.ENQ = 1'b0; a_if.DEQ = 1'b0;
        #1;
        checks++; if (a_if.VALID_OUT !== 1'b0) begin errors++; $display("FAIL reset_valid got %b exp 0", a_if.VALID_OUT); end
        checks++; if (a_if.Q_OUT !== 8'hA5) begin errors++; $display("FAIL reset_q got %h exp a5", a_if.Q_OUT); end
        checks++; if (a_if.RDY_ENQ !== 1'b1) begin errors++; $display("FAIL after_reset_rdy got %b exp 1", a_if.RDY_ENQ); end
`ifdef REG_PIPE_COUNT_EN
        checks++; if (a_if.COUNT !== 2'd0) begin errors++; $display("FAIL reset_count got %0d exp 0", a_if.COUNT); end
`endif
    endtask

    task automatic test_latency_stream();
        a_if.DEQ = 1'b1;
        for (int c = 0; c < 12; c++) begin
            a_if.ENQ  = (c < 8);
            a_if.D_IN = 8'(8'h11 + c);
            #1;
            checks++; if (a_if.RDY_ENQ !== 1'b1) begin errors++; $display("FAIL stream_rdy cyc %0d got %b exp 1", c, a_if.RDY_ENQ); end
            checks++; if (a_if.VALID_OUT !== ((c >= 3) && (c <= 10))) begin errors++; $display("FAIL stream_valid cyc %0d got %b exp %b", c, a_if.VALID_OUT, (c >= 3) && (c <= 10)); end
            if (c >= 3 && c <= 10) begin
                checks++; if (a_if.Q_OUT !== 8'(8'h11 + c - 3)) begin errors++; $display("FAIL stream_q cyc %0d got %h exp %h", c, a_if.Q_OUT, 8'(8'h11 + c - 3)); end
            end
            tick();
        end
        a_if.ENQ = 1'b0; a_if.DEQ = 1'b0;
    endtask

    task automatic test_full();
        logic [7:0] exp_seq [3];
        exp_seq[0] = 8'h22; exp_seq[1] = 8'h23; exp_seq[2] = 8'h26;
        a_if.DEQ = 1'b0;
        for (int c = 0; c < 5; c++) begin
            a_if.ENQ  = 1'b1;
            a_if.D_IN = 8'(8'h21 + c);
            #1;
            checks++; if (a_if.RDY_ENQ !== (c < 3)) begin errors++; $display("FAIL full_rdy cyc %0d got %b exp %b", c, a_if.RDY_ENQ, c < 3); end
            tick();
        end
        a_if.ENQ = 1'b0;
        tick();
        checks++; if (a_if.VALID_OUT !== 1'b1 || a_if.Q_OUT !== 8'h21) begin errors++; $display("FAIL full_head got %b/%h exp 1/21", a_if.VALID_OUT, a_if.Q_OUT); end
        checks++; if (a_if.RDY_ENQ !== 1'b0) begin errors++; $display("FAIL full_frozen_rdy got %b exp 0", a_if.RDY_ENQ); end
`ifdef REG_PIPE_COUNT_EN
        checks++; if (a_if.COUNT !== 2'd3) begin errors++; $display("FAIL full_count got %0d exp 3", a_if.COUNT); end
`endif
        a_if.ENQ = 1'b1; a_if.D_IN = 8'h26; a_if.DEQ = 1'b1;
        #1;
        checks++; if (a_if.RDY_ENQ !== 1'b1) begin errors++; $display("FAIL full_deq_rdy got %b exp 1", a_if.RDY_ENQ); end
        tick();
        a_if.ENQ = 1'b0; a_if.DEQ = 1'b0;
        #1;
        checks++; if (a_if.VALID_OUT !== 1'b1 || a_if.Q_OUT !== 8'h22) begin errors++; $display("FAIL full_swap_q got %b/%h exp 1/22", a_if.VALID_OUT, a_if.Q_OUT); end
`ifdef REG_PIPE_COUNT_EN
        checks++; if (a_if.COUNT !== 2'd3) begin errors++; $display("FAIL full_swap_count got %0d exp 3", a_if.COUNT); end
`endif
        a_if.DEQ = 1'b1;
        for (int k = 0; k < 3; k++) begin
            #1;
            checks++; if (a_if.VALID_OUT !== 1'b1 || a_if.Q_OUT !== exp_seq[k]) begin errors++; $display("FAIL full_drain %0d got %b/%h exp 1/%h", k, a_if.VALID_OUT, a_if.Q_OUT, exp_seq[k]); end
            tick();
        end
        checks++; if (a_if.VALID_OUT !== 1'b0) begin errors++; $display("FAIL full_empty got %b exp 0", a_if.VALID_OUT); end
        a_if.DEQ = 1'b0;
    endtask

    task automatic test_bubble();
        a_if.DEQ = 1'b0;
        for (int c = 0; c < 7; c++) begin
            a_if.ENQ  = (c == 0) || (c == 3);
            a_if.D_IN = (c == 0) ? 8'h01 : 8'h02;
            tick();
        end
        a_if.ENQ = 1'b0;
        #1;
        checks++; if (a_if.VALID_OUT !== 1'b1 || a_if.Q_OUT !== 8'h01) begin errors++; $display("FAIL bubble_head got %b/%h exp 1/01", a_if.VALID_OUT, a_if.Q_OUT); end
        checks++; if (a_if.RDY_ENQ !== 1'b1) begin errors++; $display("FAIL bubble_rdy got %b exp 1", a_if.RDY_ENQ); end
`ifdef REG_PIPE_COUNT_EN
        checks++; if (a_if.COUNT !== 2'd2) begin errors++; $display("FAIL bubble_count got %0d exp 2", a_if.COUNT); end
`endif
        a_if.DEQ = 1'b1;
        tick();
        checks++; if (a_if.VALID_OUT !== 1'b1 || a_if.Q_OUT !== 8'h02) begin errors++; $display("FAIL bubble_second got %b/%h exp 1/02", a_if.VALID_OUT, a_if.Q_OUT); end
        tick();
        checks++; if (a_if.VALID_OUT !== 1'b0) begin errors++; $display("FAIL bubble_empty got %b exp 0", a_if.VALID_OUT); end
        a_if.DEQ = 1'b0;
    endtask

    task automatic test_reset_midstream();
        a_if.DEQ = 1'b0;
        for (int c = 0; c < 4; c++) begin
            a_if.ENQ  = (c < 2);
            a_if.D_IN = 8'(8'h31 + c);
            tick();
        end
        a_if.ENQ = 1'b0;
        checks++; if (a_if.VALID_OUT !== 1'b1 || a_if.Q_OUT !== 8'h31) begin errors++; $display("FAIL mid_pre got %b/%h exp 1/31", a_if.VALID_OUT, a_if.Q_OUT); end
        rst = 1'b1; a_if.ENQ = 1'b1; a_if.D_IN = 8'h99; a_if.DEQ = 1'b1;
        #1;
        checks++; if (a_if.RDY_ENQ !== 1'b0) begin errors++; $display("FAIL mid_rst_rdy got %b exp 0", a_if.RDY_ENQ); end
        tick();
        rst = 1'b0; a_if.ENQ = 1'b0; a_if.DEQ = 1'b0;
        #1;
        checks++; if (a_if.VALID_OUT !== 1'b0) begin errors++; $display("FAIL mid_valid got %b exp 0", a_if.VALID_OUT); end
        checks++; if (a_if.Q_OUT !== 8'h31) begin errors++; $display("FAIL mid_stale_q got %h exp 31", a_if.Q_OUT); end
`ifdef REG_PIPE_COUNT_EN
        checks++; if (a_if.COUNT !== 2'd0) begin errors++; $display("FAIL mid_count got %0d exp 0", a_if.COUNT); end
`endif
        a_if.DEQ = 1'b1;
        for (int c = 0; c < 5; c++) begin
            a_if.ENQ  = (c == 0);
            a_if.D_IN = 8'h40;
            #1;
            checks++; if (a_if.VALID_OUT !== (c == 3)) begin errors++; $display("FAIL mid_new_valid cyc %0d got %b exp %b", c, a_if.VALID_OUT, c == 3); end
            if (c == 3) begin
                checks++; if (a_if.Q_OUT !== 8'h40) begin errors++; $display("FAIL mid_new_q got %h exp 40", a_if.Q_OUT); end
            end
            tick();
        end
        a_if.ENQ = 1'b0; a_if.DEQ = 1'b0;
    endtask

    task automatic test_random();
        for (int c = 0; c < 400; c++) begin
            rst       = ($urandom_range(0, 39) == 0);
            a_if.ENQ  = ($urandom_range(0, 99) < 60);
            a_if.DEQ  = ($urandom_range(0, 99) < 55);
            a_if.D_IN = 8'($urandom);
            #1;
            checks++; if (a_if.RDY_ENQ !== m_rdy()) begin errors++; $display("FAIL rand_rdy cyc %0d got %b exp %b", c, a_if.RDY_ENQ, m_rdy()); end
            checks++; if (a_if.VALID_OUT !== m_valid()) begin errors++; $display("FAIL rand_valid cyc %0d got %b exp %b", c, a_if.VALID_OUT, m_valid()); end
            if (m_valid()) begin
                checks++; if (a_if.Q_OUT !== 8'(m_data[0])) begin errors++; $display("FAIL rand_q cyc %0d got %h exp %h", c, a_if.Q_OUT, 8'(m_data[0])); end
            end
`ifdef REG_PIPE_COUNT_EN
            checks++; if (a_if.COUNT !== 2'(m_data.size())) begin errors++; $display("FAIL rand_count cyc %0d got %0d exp %0d", c, a_if.COUNT, m_data.size()); end
`endif
            tick();
        end
        rst = 1'b0; a_if.ENQ = 1'b0; a_if.DEQ = 1'b0;
    endtask

    task automatic test_depth1();
        b_if.DEQ = 1'b1;
        for (int c = 0; c < 6; c++) begin
            b_if.ENQ  = 1'b1;
            b_if.D_IN = c[0];
            #1;
            checks++; if (b_if.RDY_ENQ !== 1'b1) begin errors++; $display("FAIL d1_rate_rdy cyc %0d got %b exp 1", c, b_if.RDY_ENQ); end
            checks++; if (b_if.VALID_OUT !== (c > 0)) begin errors++; $display("FAIL d1_rate_valid cyc %0d got %b exp %b", c, b_if.VALID_OUT, c > 0); end
            if (c > 0) begin
                checks++; if (b_if.Q_OUT !== ~c[0]) begin errors++; $display("FAIL d1_rate_q cyc %0d got %b exp %b", c, b_if.Q_OUT, ~c[0]); end
            end
            tick();
        end
        b_if.ENQ = 1'b0;
        tick();
        checks++; if (b_if.VALID_OUT !== 1'b0) begin errors++; $display("FAIL d1_drain got %b exp 0", b_if.VALID_OUT); end
        b_if.DEQ = 1'b0; b_if.ENQ = 1'b1; b_if.D_IN = 1'b0;
        #1;
        checks++; if (b_if.RDY_ENQ !== 1'b1) begin errors++; $display("FAIL d1_first_rdy got %b exp 1", b_if.RDY_ENQ); end
        tick();
        b_if.D_IN = 1'b1;
        #1;
        checks++; if (b_if.RDY_ENQ !== 1'b0) begin errors++; $display("FAIL d1_second_rdy got %b exp 0", b_if.RDY_ENQ); end
        tick();
        checks++; if (b_if.VALID_OUT !== 1'b1 || b_if.Q_OUT !== 1'b0) begin errors++; $display("FAIL d1_hold got %b/%b exp 1/0", b_if.VALID_OUT, b_if.Q_OUT); end
`ifdef REG_PIPE_COUNT_EN
        checks++; if (b_if.COUNT !== 2'd1) begin errors++; $display("FAIL d1_count got %0d exp 1", b_if.COUNT); end
`endif
        b_if.DEQ = 1'b1;
        #1;
        checks++; if (b_if.RDY_ENQ !== 1'b1) begin errors++; $display("FAIL d1_deq_rdy got %b exp 1", b_if.RDY_ENQ); end
        tick();
        checks++; if (b_if.VALID_OUT !== 1'b1 || b_if.Q_OUT !== 1'b1) begin errors++; $display("FAIL d1_swap got %b/%b exp 1/1", b_if.VALID_OUT, b_if.Q_OUT); end
        b_if.ENQ = 1'b0;
        tick();
        b_if.DEQ = 1'b0;
    endtask

    initial begin
        test_reset();
        test_latency_stream();
        test_full();
        test_bubble();
        test_reset_midstream();
        test_random();
        test_depth1();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
